// File: rtl/isa_pkg.sv
// rtl/isa_pkg.sv - shared types and defaults for the ISA register-port arbiter
package isa_pkg;

  localparam int DEF_N_REQ    = 4;
  localparam int DEF_REG_W    = 64;
  localparam int DEF_ID_W     = 4;
  localparam int DEF_MAX_HOLD = 16;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_OWN  = 1'b1
  } arb_state_t;

  // Next round-robin position after idx, wrapping n-1 -> 0
  function automatic int rr_next(input int idx, input int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/isa_reg_arbiter_if.sv
// rtl/isa_reg_arbiter_if.sv - unit-bank side bundle of the register-port arbiter
interface isa_reg_arbiter_if #(
  parameter int N_REQ = 4,
  parameter int REG_W = 64,
  parameter int ID_W  = 4
);

  logic [N_REQ-1:0]       req;
  logic [N_REQ-1:0]       lock;
  logic [N_REQ*ID_W-1:0]  u_id;
  logic [N_REQ-1:0]       u_re;
  logic [N_REQ-1:0]       u_we;
  logic [N_REQ*REG_W-1:0] u_wd;
  logic [N_REQ-1:0]       gnt;
  logic [REG_W-1:0]       rd_data;
  logic [N_REQ-1:0]       rd_valid;
  logic                   timeout;

  // Execution-unit bank side
  modport master (
    output req, lock, u_id, u_re, u_we, u_wd,
    input  gnt, rd_data, rd_valid, timeout
  );

  // Arbiter side
  modport slave (
    input  req, lock, u_id, u_re, u_we, u_wd,
    output gnt, rd_data, rd_valid, timeout
  );

endinterface

// File: rtl/isa_rr_pick.sv
// rtl/isa_rr_pick.sv - combinational round-robin picker starting at a pointer
module isa_rr_pick #(
  parameter int N_REQ = 4,
  parameter int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N_REQ-1:0] pick,
  output logic [IDX_W-1:0] pick_idx
);

  logic [IDX_W-1:0] cand;
  logic             found;

  // Scan from ptr upward with wrap and take the first asserted request
  always_comb begin
    pick     = '0;
    pick_idx = '0;
    cand     = '0;
    found    = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      cand = IDX_W'((int'(ptr) + i) % N_REQ);
      if (!found && req[cand]) begin
        found    = 1'b1;
        pick_idx = cand;
      end
    end
    if (found) begin
      pick[pick_idx] = 1'b1;
    end
  end

endmodule

// File: rtl/isa_reg_arbiter.sv
// rtl/isa_reg_arbiter.sv - round-robin arbiter sharing the register-file port among ISA units
module isa_reg_arbiter
  import isa_pkg::*;
#(
  parameter int N_REQ    = DEF_N_REQ,
  parameter int REG_W    = DEF_REG_W,
  parameter int ID_W     = DEF_ID_W,
  parameter int MAX_HOLD = DEF_MAX_HOLD
) (
  input  logic             clk,
  input  logic             rst,
  isa_reg_arbiter_if.slave bus,
  output logic [ID_W-1:0]  reg_id,
  output logic             reg_re,
  output logic             reg_we,
  output logic [REG_W-1:0] reg_wd,
  input  logic [REG_W-1:0] reg_out
);

  localparam int IDX_W  = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int HOLD_W = $clog2(MAX_HOLD);

  arb_state_t        state_q, state_d;
  logic [IDX_W-1:0]  owner_q, owner_d;
  logic [IDX_W-1:0]  rr_ptr_q, rr_ptr_d;
  logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
  logic              timeout_q, timeout_d;
  // One-hot of the unit whose read is returning; latched at issue so the
  // pulse reaches the issuer even if its grant has already dropped.
  logic [N_REQ-1:0]  rd_valid_q, rd_valid_d;

  logic [N_REQ-1:0]  pick;
  logic [IDX_W-1:0]  pick_idx;

  logic              granted;
  logic              own_re, own_we;
  logic [ID_W-1:0]   own_id;
  logic [REG_W-1:0]  own_wd;
  logic              access;
  logic              rel_req, rel_lock, rel_hold, release_now;

  isa_rr_pick #(
    .N_REQ (N_REQ),
    .IDX_W (IDX_W)
  ) u_pick (
    .req      (bus.req),
    .ptr      (rr_ptr_q),
    .pick     (pick),
    .pick_idx (pick_idx)
  );

  // Owner's strobes onto the register-file port, gated to zero without a grant
  always_comb begin
    granted = (state_q == ST_OWN);
    own_re  = bus.u_re[owner_q];
    own_we  = bus.u_we[owner_q];
    own_id  = bus.u_id[int'(owner_q)*ID_W +: ID_W];
    own_wd  = bus.u_wd[int'(owner_q)*REG_W +: REG_W];
    reg_re  = granted & own_re;
    reg_we  = granted & own_we;
    reg_id  = granted ? own_id : '0;
    reg_wd  = granted ? own_wd : '0;
    access  = reg_re | reg_we;
  end

  // One-hot grant decoded from the FSM
  always_comb begin
    bus.gnt = '0;
    if (granted) begin
      bus.gnt[owner_q] = 1'b1;
    end
  end

  assign bus.rd_valid = rd_valid_q;
  assign bus.rd_data  = (|rd_valid_q) ? reg_out : '0;
  assign bus.timeout  = timeout_q;

  // Release conditions for the current owner
  always_comb begin
    rel_req     = ~bus.req[owner_q];
    rel_lock    = ~bus.lock[owner_q] & access;
    rel_hold    = (hold_cnt_q == HOLD_W'(MAX_HOLD - 1));
    release_now = rel_req | rel_lock | rel_hold;
  end

  // Next-state, owner, pointer, hold counter and read-return decode
  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    rr_ptr_d   = rr_ptr_q;
    hold_cnt_d = hold_cnt_q;
    timeout_d  = 1'b0;
    rd_valid_d = '0;
    if (reg_re) begin
      rd_valid_d[owner_q] = 1'b1;
    end
    case (state_q)
      ST_IDLE: begin
        if (|pick) begin
          state_d    = ST_OWN;
          owner_d    = pick_idx;
          hold_cnt_d = '0;
        end
      end
      ST_OWN: begin
        hold_cnt_d = hold_cnt_q + 1'b1;
        if (release_now) begin
          state_d    = ST_IDLE;
          hold_cnt_d = '0;
          rr_ptr_d   = IDX_W'(rr_next(int'(owner_q), N_REQ));
          timeout_d  = rel_hold & ~rel_req & ~rel_lock;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State registers; reset also drops any read still in flight
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      owner_q    <= '0;
      rr_ptr_q   <= '0;
      hold_cnt_q <= '0;
      timeout_q  <= 1'b0;
      rd_valid_q <= '0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      rr_ptr_q   <= rr_ptr_d;
      hold_cnt_q <= hold_cnt_d;
      timeout_q  <= timeout_d;
      rd_valid_q <= rd_valid_d;
    end
  end

endmodule
